// File: rtl/usb_page_stager_pkg.sv
// Shared definitions for the USB page stager.
//   PAGE_WORDS_DEF : default words per SDRAM page burst (power of two)
//   IDLE/ARMED/DRAIN : drain FSM state encodings
//   ON/OFF         : single-bit control levels
//   pages_next()   : pending-page count update for simultaneous fill/drain
package usb_page_stager_pkg;

  localparam int unsigned PAGE_WORDS_DEF = 512;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam logic [1:0] PAGES_MAX = 2'd2;

  // A fill completing on the same edge as a drain leaves the count unchanged.
  function automatic logic [1:0] pages_next(input logic [1:0] cur,
                                            input logic       inc,
                                            input logic       dec);
    logic [1:0] nxt;
    nxt = cur;
    case ({inc, dec})
      2'b10:   nxt = cur + 2'd1;
      2'b01:   nxt = cur - 2'd1;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/page_buffer_ram.sv
// Simple dual-port RAM backing the two ping-pong pages.
//   clk       : clock
//   wr_en_i   : write strobe (fill side)
//   wr_addr_i : {page_bit, idx} write address
//   wr_data_i : write word
//   rd_addr_i : {page_bit, idx} read address (drain side)
//   rd_data_o : registered read word, one cycle after the address
module page_buffer_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  // No reset on the array or read register so this maps onto block RAM.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/usb_page_stager.sv
// Ping-pong page stager between the USB receive stream and the SDRAM
// controller's full-page write burst.
//   clk           : system clock (48 MHz)
//   n_rst         : synchronous active-low reset
//   in_data       : incoming stream word
//   in_valid      : in_data valid; transfers when in_valid && in_ready
//   in_ready      : room for another word (fewer than two full pages held)
//   fifo_tx_rdy   : a full page is pending and no drain is running
//   sdram_rx_rdy  : controller pulse starting the page burst
//   data          : drained page word, zero outside a drain
//   pages_pending : full pages held (0..2)
//
// Drain FSM
//   state | meaning
//   IDLE  | no full page held
//   ARMED | full page held, fifo_tx_rdy offered, waiting for sdram_rx_rdy
//   DRAIN | reading the drain page out one word per clock
module usb_page_stager
  import usb_page_stager_pkg::*;
#(
  parameter int PAGE_WORDS = PAGE_WORDS_DEF,
  parameter int IDX_W      = $clog2(PAGE_WORDS)
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        fifo_tx_rdy,
  input  logic        sdram_rx_rdy,
  output logic [15:0] data,
  output logic [1:0]  pages_pending
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAGE_WORDS - 1);

  logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
  logic [IDX_W-1:0] drain_idx_q, drain_idx_d;
  logic             fill_page_q, fill_page_d;
  logic             drain_page_q, drain_page_d;
  logic [1:0]       pages_q, pages_d;
  logic [1:0]       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             tx_rdy_q, tx_rdy_d;
  logic             rd_vld_q, rd_vld_d;
  logic             accept, fill_done, drain_done;
  logic [15:0]      rd_data;

  assign accept     = in_valid && in_ready_q;
  assign fill_done  = accept && (fill_idx_q == LAST_IDX);
  // The read of the last word is issued on this edge, so the page is free
  // for the fill side from the next edge on.
  assign drain_done = (state_q == DRAIN) && (drain_idx_q == LAST_IDX);

  always_comb begin
    fill_idx_d   = accept ? fill_idx_q + IDX_W'(1) : fill_idx_q;
    fill_page_d  = fill_page_q ^ fill_done;
    pages_d      = pages_next(pages_q, fill_done, drain_done);
    in_ready_d   = (pages_d < PAGES_MAX);
    state_d      = state_q;
    drain_idx_d  = drain_idx_q;
    drain_page_d = drain_page_q;
    rd_vld_d     = OFF;
    case (state_q)
      IDLE: begin
        if (pages_q != 2'd0) state_d = ARMED;
      end
      ARMED: begin
        if (sdram_rx_rdy) begin
          state_d     = DRAIN;
          drain_idx_d = '0;
        end
      end
      DRAIN: begin
        rd_vld_d    = ON;
        drain_idx_d = drain_idx_q + IDX_W'(1);
        if (drain_done) begin
          drain_page_d = ~drain_page_q;
          state_d      = (pages_d != 2'd0) ? ARMED : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Offered only once ARMED has been held for a cycle, and withdrawn on the
    // edge that accepts sdram_rx_rdy.
    tx_rdy_d = (state_q == ARMED) && (state_d == ARMED);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      fill_idx_q   <= '0;
      drain_idx_q  <= '0;
      fill_page_q  <= OFF;
      drain_page_q <= OFF;
      pages_q      <= 2'd0;
      state_q      <= IDLE;
      in_ready_q   <= ON;
      tx_rdy_q     <= OFF;
      rd_vld_q     <= OFF;
    end else begin
      fill_idx_q   <= fill_idx_d;
      drain_idx_q  <= drain_idx_d;
      fill_page_q  <= fill_page_d;
      drain_page_q <= drain_page_d;
      pages_q      <= pages_d;
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      tx_rdy_q     <= tx_rdy_d;
      rd_vld_q     <= rd_vld_d;
    end
  end

  page_buffer_ram #(
    .ADDR_W(IDX_W + 1),
    .DATA_W(16)
  ) u_ram (
    .clk      (clk),
    .wr_en_i  (accept),
    .wr_addr_i({fill_page_q, fill_idx_q}),
    .wr_data_i(in_data),
    .rd_addr_i({drain_page_q, drain_idx_q}),
    .rd_data_o(rd_data)
  );

  assign data          = rd_vld_q ? rd_data : 16'h0000;
  assign in_ready      = in_ready_q;
  assign fifo_tx_rdy   = tx_rdy_q;
  assign pages_pending = pages_q;

endmodule

// File: tb/tb_usb_page_stager.sv
// Directed bench for usb_page_stager with hand-computed expectations.
module tb_usb_page_stager;

  localparam int PW = 512;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        in_valid = 1'b0;
  logic        sdram_rx_rdy = 1'b0;
  logic        in_ready;
  logic        fifo_tx_rdy;
  logic [15:0] data;
  logic [1:0]  pages_pending;

  int n_checks = 0;
  int n_fail   = 0;

  usb_page_stager #(
    .PAGE_WORDS(PW),
    .IDX_W(9)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .fifo_tx_rdy  (fifo_tx_rdy),
    .sdram_rx_rdy (sdram_rx_rdy),
    .data         (data),
    .pages_pending(pages_pending)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed n consecutive words base, base+1, ...; every one is expected to find
  // in_ready high.
  task automatic fill(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      check_eq("in_ready_fill", {15'b0, in_ready}, 16'h0001);
      in_valid = 1'b1;
      in_data  = base + 16'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_armed();
    int guard;
    guard = 0;
    while (fifo_tx_rdy !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check_eq("tx_rdy_wait", {15'b0, fifo_tx_rdy}, 16'h0001);
  endtask

  // Full drain: word 0 expected as first_w, word k>0 as base+k. From drain
  // cycle feed_from onward, word 16'h2000+k is fed alongside on each edge.
  task automatic drain_check(input logic [15:0] first_w, input logic [15:0] base,
                             input int feed_from);
    wait_armed();
    sdram_rx_rdy = 1'b1;
    tick();
    sdram_rx_rdy = 1'b0;
    check_eq("tx_rdy_drop", {15'b0, fifo_tx_rdy}, 16'h0000);
    for (int k = 0; k < PW; k++) begin
      if (k >= feed_from) begin
        in_valid = 1'b1;
        in_data  = 16'h2000 + 16'(k);
      end
      tick();
      check_eq("drain_word", data, (k == 0) ? first_w : base + 16'(k));
    end
    if (feed_from < PW) in_valid = 1'b0;
    tick();
    check_eq("data_after_drain", data, 16'h0000);
    in_valid = 1'b0;
  endtask

  initial begin
    // reset
    n_rst = 1'b0;
    tick();
    tick();
    check_eq("rst_in_ready", {15'b0, in_ready}, 16'h0001);
    check_eq("rst_tx_rdy", {15'b0, fifo_tx_rdy}, 16'h0000);
    check_eq("rst_data", data, 16'h0000);
    check_eq("rst_pages", {14'b0, pages_pending}, 16'h0000);
    n_rst = 1'b1;

    // one page, fifo_tx_rdy two cycles after the last accept
    fill(16'h0000, PW);
    check_eq("pages_after_fill", {14'b0, pages_pending}, 16'h0001);
    tick();
    check_eq("tx_rdy_plus1", {15'b0, fifo_tx_rdy}, 16'h0000);
    tick();
    check_eq("tx_rdy_plus2", {15'b0, fifo_tx_rdy}, 16'h0001);
    check_eq("in_ready_one_page", {15'b0, in_ready}, 16'h0001);

    // drain it
    drain_check(16'h0000, 16'h0000, PW);
    check_eq("pages_after_drain", {14'b0, pages_pending}, 16'h0000);
    check_eq("tx_rdy_idle", {15'b0, fifo_tx_rdy}, 16'h0000);

    // two pages, back-pressure, held word lands as word 0 of the freed page
    fill(16'h1000, 2 * PW);
    check_eq("pages_full", {14'b0, pages_pending}, 16'h0002);
    check_eq("in_ready_full", {15'b0, in_ready}, 16'h0000);
    in_valid = 1'b1;
    in_data  = 16'hABCD;
    repeat (5) tick();
    check_eq("held_in_ready", {15'b0, in_ready}, 16'h0000);
    check_eq("held_pages", {14'b0, pages_pending}, 16'h0002);
    drain_check(16'h1000, 16'h1000, PW);
    check_eq("pages_after_bp_drain", {14'b0, pages_pending}, 16'h0001);
    check_eq("in_ready_after_bp", {15'b0, in_ready}, 16'h0001);

    // drain page 1 while filling page 0; fill ends on the drain-ending edge
    drain_check(16'h1200, 16'h1200, 1);
    check_eq("pages_simul", {14'b0, pages_pending}, 16'h0001);
    check_eq("tx_rdy_rearmed", {15'b0, fifo_tx_rdy}, 16'h0001);
    drain_check(16'hABCD, 16'h2000, PW);
    check_eq("pages_after_simul", {14'b0, pages_pending}, 16'h0000);

    // reset at drain word 100
    fill(16'h3000, PW);
    wait_armed();
    sdram_rx_rdy = 1'b1;
    tick();
    sdram_rx_rdy = 1'b0;
    for (int k = 0; k <= 100; k++) begin
      tick();
      check_eq("pre_rst_word", data, 16'h3000 + 16'(k));
    end
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    check_eq("mid_rst_data", data, 16'h0000);
    check_eq("mid_rst_tx_rdy", {15'b0, fifo_tx_rdy}, 16'h0000);
    check_eq("mid_rst_pages", {14'b0, pages_pending}, 16'h0000);
    check_eq("mid_rst_in_ready", {15'b0, in_ready}, 16'h0001);
    fill(16'h4000, PW);
    drain_check(16'h4000, 16'h4000, PW);

    // sdram_rx_rdy while IDLE with a partial page
    fill(16'h5000, 300);
    sdram_rx_rdy = 1'b1;
    repeat (3) begin
      tick();
      check_eq("idle_rx_data", data, 16'h0000);
      check_eq("idle_rx_tx_rdy", {15'b0, fifo_tx_rdy}, 16'h0000);
    end
    sdram_rx_rdy = 1'b0;
    check_eq("idle_rx_pages", {14'b0, pages_pending}, 16'h0000);
    fill(16'h5000 + 16'd300, PW - 300);
    drain_check(16'h5000, 16'h5000, PW);
    check_eq("final_pages", {14'b0, pages_pending}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
